// File: rtl/dfm_axi_master.sv
// AXI4-Lite-subset initiator for the frequency-meter slave: program shift/total, await done, snapshot, read 64-bit result.
// Optional WAIT_DONE watchdog enabled by defining DFM_MASTER_TIMEOUT_EN.
module dfm_axi_master #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [7:0]  SNAP_OFFSET    = 8'h10,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic        start_i,
  input  logic [31:0] cfg_shift_i,
  input  logic [31:0] cfg_total_i,
  input  logic        done_i,
  output logic        busy_o,
  output logic [63:0] result_o,
  output logic        result_valid_o,
  output logic        err_o,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {
    IDLE, WR_SHIFT, WR_TOTAL, WAIT_DONE, WR_SNAP, RD_HI, RD_LO
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   total_q, hi_q, wdata_q;
  logic [AW-1:0]   awaddr_q, araddr_q;
  logic [2*DW-1:0] result_q;
  logic            done_seen_q, busy_q, result_valid_q;
  logic            awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic            wr_state_c, b_hs_c, r_hs_c, aw_ok_c, w_ok_c;

  assign wr_state_c = (state_q == WR_SHIFT) || (state_q == WR_TOTAL) || (state_q == WR_SNAP);
  assign b_hs_c     = m_axi_bvalid && bready_q;
  assign r_hs_c     = m_axi_rvalid && rready_q;
  // A channel counts as accepted once its valid has dropped or is being taken this cycle
  assign aw_ok_c    = !awvalid_q || m_axi_awready;
  assign w_ok_c     = !wvalid_q || m_axi_wready;

`ifdef DFM_MASTER_TIMEOUT_EN
  logic [31:0] wd_cnt_q;
  logic        err_q;
  logic        timeout_c;

  assign timeout_c = (wd_cnt_q == TIMEOUT_CYCLES - 32'd1);
  assign err_o     = err_q;

  // Watchdog restarts from zero on every WAIT_DONE entry
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wd_cnt_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      err_q    <= (state_q == WAIT_DONE) && (state_d == IDLE);
      wd_cnt_q <= (state_q == WAIT_DONE) ? wd_cnt_q + 32'd1 : 32'd0;
    end
  end
`else
  logic unused_timeout_c;
  assign unused_timeout_c = ^TIMEOUT_CYCLES;
  assign err_o            = 1'b0;
`endif

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_i) state_d = WR_SHIFT;
      WR_SHIFT:  if (b_hs_c) state_d = WR_TOTAL;
      WR_TOTAL:  if (b_hs_c) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (done_i || done_seen_q) state_d = WR_SNAP;
`ifdef DFM_MASTER_TIMEOUT_EN
        else if (timeout_c) state_d = IDLE;
`endif
      end
      WR_SNAP:   if (b_hs_c) state_d = RD_HI;
      RD_HI:     if (r_hs_c) state_d = RD_LO;
      RD_LO:     if (r_hs_c) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Channel handshakes: valids are launched on state entry and retire independently
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      total_q        <= '0;
      hi_q           <= '0;
      wdata_q        <= '0;
      awaddr_q       <= '0;
      araddr_q       <= '0;
      result_q       <= '0;
      done_seen_q    <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      bready_q       <= 1'b0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      busy_q         <= (state_d != IDLE);

      if (state_q == IDLE) begin
        if (start_i) begin
          total_q     <= cfg_total_i;
          done_seen_q <= 1'b0;
        end
      end else if (done_i) begin
        done_seen_q <= 1'b1;
      end

      if (state_d != state_q) begin
        awvalid_q <= 1'b0;
        wvalid_q  <= 1'b0;
        bready_q  <= 1'b0;
        arvalid_q <= 1'b0;
        rready_q  <= 1'b0;
        case (state_d)
          WR_SHIFT: begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            awaddr_q  <= BASE_ADDR;
            wdata_q   <= cfg_shift_i;
          end
          WR_TOTAL: begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            awaddr_q  <= BASE_ADDR + 32'h4;
            wdata_q   <= total_q;
          end
          WR_SNAP: begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            awaddr_q  <= BASE_ADDR + AW'(SNAP_OFFSET);
            wdata_q   <= '0;
          end
          RD_HI: begin
            arvalid_q <= 1'b1;
            araddr_q  <= BASE_ADDR + 32'h8;
          end
          RD_LO: begin
            arvalid_q <= 1'b1;
            araddr_q  <= BASE_ADDR + 32'hC;
          end
          default: ;
        endcase
      end else begin
        if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_q  <= 1'b0;
        if (wr_state_c && !bready_q && aw_ok_c && w_ok_c) bready_q <= 1'b1;
        if (arvalid_q && m_axi_arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
        end
      end

      if (r_hs_c) begin
        if (state_q == RD_HI) begin
          hi_q <= m_axi_rdata;
        end else if (state_q == RD_LO) begin
          result_q       <= {hi_q, m_axi_rdata};
          result_valid_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o         = busy_q;
  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;
  assign m_axi_awaddr   = awaddr_q;
  assign m_axi_awvalid  = awvalid_q;
  assign m_axi_wdata    = wdata_q;
  assign m_axi_wvalid   = wvalid_q;
  assign m_axi_bready   = bready_q;
  assign m_axi_araddr   = araddr_q;
  assign m_axi_arvalid  = arvalid_q;
  assign m_axi_rready   = rready_q;

endmodule
